// File: rtl/cpu_pkg.sv
// Shared pipeline constants: control-flow opcodes, branch funct3 encodings
// and the branch resolve unit FSM state type.
package cpu_pkg;

  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } brs_state_e;

endpackage

// File: rtl/br_compare.sv
// Conditional branch comparator.
//   funct3   : branch condition select
//   rs1, rs2 : forwarded operands
//   taken    : condition holds (reserved funct3 010/011 -> not taken)
module br_compare
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution and mispredict recovery.
//   clk, rst (async, active-low)
//   ex_*            : instruction in EX with operands and fetch-time prediction
//   stall           : EX held; blocks commit
//   redirect_valid/pc : one-cycle corrected-PC strobe to IF
//   flush           : kill wrong-path IF/ID and ID/EX for FLUSH_CYCLES cycles
//   upd_valid/pc/taken : predictor training update, one per commit
//   br_count, mis_count : saturating resolved / mispredicted counters
module branch_resolve_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned XLEN         = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             stall,
  input  logic [6:0]       ex_opcode,
  input  logic [2:0]       ex_funct3,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [PC_W-1:0]  ex_imm,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush,
  output logic             upd_valid,
  output logic [7:0]       upd_pc,
  output logic             upd_taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);

  brs_state_e       state_q, state_d;
  logic [FC_W-1:0]  cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic             upd_valid_q, upd_valid_d;
  logic [7:0]       upd_pc_q, upd_pc_d;
  logic             upd_taken_q, upd_taken_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mis_count_q, mis_count_d;

  logic            cmp_taken;
  logic            is_cf, is_jump, commit, actual_taken, mispredict;
  logic [PC_W-1:0] target, next_pc;

  br_compare #(.XLEN(XLEN)) u_cmp (
    .funct3 (ex_funct3),
    .rs1    (rs1_data),
    .rs2    (rs2_data),
    .taken  (cmp_taken)
  );

  // Direction, target and mispredict detection for the EX instruction.
  always_comb begin
    is_jump      = (ex_opcode == JAL) || (ex_opcode == JALR);
    is_cf        = is_jump || (ex_opcode == BRANCH);
    commit       = ex_valid && !stall && (state_q == IDLE) && is_cf;
    actual_taken = is_jump || cmp_taken;
    if (ex_opcode == JALR) begin
      target = (rs1_data[PC_W-1:0] + ex_imm) & ~PC_W'(1);
    end else begin
      target = ex_pc + ex_imm;
    end
    next_pc    = actual_taken ? target : (ex_pc + PC_W'(4));
    // A not-taken prediction is correct for a not-taken branch whatever the target.
    mispredict = (actual_taken != ex_pred_taken) ||
                 (actual_taken && (target != ex_pred_target));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    upd_valid_d      = 1'b0;
    upd_pc_d         = upd_pc_q;
    upd_taken_d      = upd_taken_q;
    br_count_d       = br_count_q;
    mis_count_d      = mis_count_q;

    case (state_q)
      IDLE: begin
        if (commit) begin
          upd_valid_d = 1'b1;
          upd_pc_d    = ex_pc[7:0];
          upd_taken_d = actual_taken;
          br_count_d  = (&br_count_q) ? br_count_q : br_count_q + CNT_W'(1);
          if (mispredict) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = next_pc;
            mis_count_d      = (&mis_count_q) ? mis_count_q : mis_count_q + CNT_W'(1);
            cnt_d            = FC_W'(FLUSH_CYCLES);
            flush_d          = 1'b1;
            state_d          = FLUSH;
          end
        end
      end
      FLUSH: begin
        // EX is wrong-path here; stall is ignored and nothing commits.
        cnt_d = cnt_q - FC_W'(1);
        if (cnt_d == '0) begin
          state_d = IDLE;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_taken_q      <= 1'b0;
      br_count_q       <= '0;
      mis_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      upd_valid_q      <= upd_valid_d;
      upd_pc_q         <= upd_pc_d;
      upd_taken_q      <= upd_taken_d;
      br_count_q       <= br_count_d;
      mis_count_q      <= mis_count_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign br_count       = br_count_q;
  assign mis_count      = mis_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_branch_resolve_unit;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned FC    = 2;
  localparam int unsigned CNT_W = 6;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid, stall, ex_pred_taken;
  logic [6:0]       ex_opcode;
  logic [2:0]       ex_funct3;
  logic [PC_W-1:0]  ex_pc, ex_imm, ex_pred_target;
  logic [XLEN-1:0]  rs1_data, rs2_data;
  logic             redirect_valid, flush, upd_valid, upd_taken;
  logic [PC_W-1:0]  redirect_pc;
  logic [7:0]       upd_pc;
  logic [CNT_W-1:0] br_count, mis_count;

  int checks = 0;
  int errors = 0;

  // Model state: remaining flush cycles after the current edge, held outputs, counts.
  int              m_rem;
  logic            e_rv, e_uv, e_utk;
  logic [PC_W-1:0] e_rpc;
  logic [7:0]      e_upc;
  int              e_br, e_mis;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .PC_W(PC_W), .XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .stall(stall),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_imm(ex_imm),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .br_count(br_count), .mis_count(mis_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; e_rv = 0; e_uv = 0; e_utk = 0; e_rpc = '0; e_upc = '0;
    e_br = 0; e_mis = 0;
  endtask

  task automatic check_all();
    chk("redirect_valid", 64'(redirect_valid), 64'(e_rv));
    chk("redirect_pc",    64'(redirect_pc),    64'(e_rpc));
    chk("flush",          64'(flush),          64'(m_rem > 0));
    chk("upd_valid",      64'(upd_valid),      64'(e_uv));
    chk("upd_pc",         64'(upd_pc),         64'(e_upc));
    chk("upd_taken",      64'(upd_taken),      64'(e_utk));
    chk("br_count",       64'(br_count),       64'(e_br));
    chk("mis_count",      64'(mis_count),      64'(e_mis));
  endtask

  function automatic logic ref_taken(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [63:0] a, input logic [63:0] b);
    if (op == OP_JAL || op == OP_JALR) return 1'b1;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: predict from current inputs, advance, then compare.
  task automatic cycle();
    logic            is_cf, commit, tk, mis;
    logic [PC_W-1:0] tgt, npc;
    is_cf  = (ex_opcode == OP_BR) || (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR);
    commit = ex_valid && !stall && (m_rem == 0) && is_cf;
    tk     = ref_taken(ex_opcode, ex_funct3, rs1_data, rs2_data);
    tgt    = (ex_opcode == OP_JALR) ? ((rs1_data[31:0] + ex_imm) & 32'hFFFF_FFFE)
                                    : (ex_pc + ex_imm);
    npc    = tk ? tgt : ex_pc + 32'd4;
    mis    = (tk != ex_pred_taken) || (tk && (tgt != ex_pred_target));
    @(posedge clk);
    #1;
    e_uv = commit;
    e_rv = commit && mis;
    if (m_rem > 0) m_rem--;
    if (commit) begin
      e_upc = ex_pc[7:0];
      e_utk = tk;
      if (e_br < CMAX) e_br++;
      if (mis) begin
        if (e_mis < CMAX) e_mis++;
        e_rpc = npc;
        m_rem = FC;
      end
    end
    check_all();
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic pt, input logic [31:0] ptgt);
    ex_valid = v; ex_opcode = op; ex_funct3 = f3; ex_pc = pc; ex_imm = imm;
    rs1_data = a; rs2_data = b; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic idle(input int n);
    ex_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0;
    drive(1'b0, OP_ALU, 3'd0, 32'h0, 32'h0, 64'h0, 64'h0, 1'b0, 32'h0);
    model_reset();
    #12;
    check_all();
    @(negedge clk); rst = 1'b1;

    // BEQ correctly predicted taken.
    drive(1'b1, OP_BR, 3'b000, 32'h100, 32'h20, 64'd5, 64'd5, 1'b1, 32'h120);
    cycle();
    chk("beq_upd", {upd_valid, upd_taken, upd_pc}, {1'b1, 1'b1, 8'h00});
    idle(1);

    // BLT signed, actually taken, predicted not taken.
    drive(1'b1, OP_BR, 3'b100, 32'h200, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
          1'b0, 32'h0);
    cycle();
    chk("blt_redirect", 64'(redirect_pc), 64'h1F8);
    idle(3);

    // JALR: matching target, then mismatching target.
    drive(1'b1, OP_JALR, 3'b000, 32'h300, 32'd4, 64'h1001, 64'h0, 1'b1, 32'h1004);
    cycle();
    chk("jalr_hit_norv", 64'(redirect_valid), 64'h0);
    ex_pred_target = 32'h1000;
    cycle();
    chk("jalr_miss_pc", 64'(redirect_pc), 64'h1004);

    // Valid BNE during the flush window must be ignored.
    drive(1'b1, OP_BR, 3'b001, 32'h400, 32'h10, 64'd1, 64'd2, 1'b0, 32'h0);
    cycle();
    cycle();
    idle(1);

    // BGEU held by stall for 3 cycles, then released.
    drive(1'b1, OP_BR, 3'b111, 32'h5A4, 32'h40, 64'd9, 64'd3, 1'b1, 32'h5E4);
    stall = 1'b1;
    cycle(); cycle(); cycle();
    stall = 1'b0;
    cycle();
    idle(1);

    // Asynchronous reset in the middle of a flush.
    drive(1'b1, OP_JAL, 3'b000, 32'h600, 32'h80, 64'h0, 64'h0, 1'b0, 32'h0);
    cycle();
    ex_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk); rst = 1'b1;
    idle(1);

    // Randomized traffic; counters are narrow so saturation is reached.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] sel;
      sel = 3'($urandom_range(0, 4));
      ex_opcode = (sel <= 3'd1) ? OP_BR : (sel == 3'd2) ? OP_JAL :
                  (sel == 3'd3) ? OP_JALR : OP_ALU;
      ex_valid  = ($urandom_range(0, 99) < 85);
      stall     = ($urandom_range(0, 99) < 20);
      ex_funct3 = 3'($urandom_range(0, 7));
      ex_pc     = {$urandom()} & 32'hFFFF_FFFC;
      ex_imm    = 32'($signed(12'($urandom_range(0, 4095))));
      rs1_data  = {$urandom(), $urandom()};
      rs2_data  = ($urandom_range(0, 1) == 0) ? rs1_data : {$urandom(), $urandom()};
      ex_pred_taken  = 1'($urandom_range(0, 1));
      ex_pred_target = ($urandom_range(0, 1) == 0) ? ex_pc + ex_imm : $urandom();
      cycle();
    end
    idle(FC + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
